aes_top: RTL and testbench

//  Iterative AES-128 encryption core (FIPS-197), cipher direction only; one round per clock.
//  Top of the AES datapath: captures a 128-bit plaintext and key on a start request.

---
 rtl/aes_pkg.sv | 31 +++
 rtl/aes_sbox.sv | 45 ++++
 rtl/aes_top.sv | 128 ++++++++++++
 tb/tb_aes_top.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, round-constant table, GF(2^8) helpers and FSM state type.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int NR      = 10;

  // Indexed directly by the round number (1..10); unused slots are zero.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1B, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic {IDLE, BUSY} aes_fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    mix_column[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    mix_column[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    mix_column[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    mix_column[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte per instance.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  always_comb begin
    o_byte = 8'h00;
    case (i_byte)
      8'h00: o_byte = 8'h63; 8'h01: o_byte = 8'h7c; 8'h02: o_byte = 8'h77; 8'h03: o_byte = 8'h7b; 8'h04: o_byte = 8'hf2; 8'h05: o_byte = 8'h6b; 8'h06: o_byte = 8'h6f; 8'h07: o_byte = 8'hc5;
      8'h08: o_byte = 8'h30; 8'h09: o_byte = 8'h01; 8'h0a: o_byte = 8'h67; 8'h0b: o_byte = 8'h2b; 8'h0c: o_byte = 8'hfe; 8'h0d: o_byte = 8'hd7; 8'h0e: o_byte = 8'hab; 8'h0f: o_byte = 8'h76;
      8'h10: o_byte = 8'hca; 8'h11: o_byte = 8'h82; 8'h12: o_byte = 8'hc9; 8'h13: o_byte = 8'h7d; 8'h14: o_byte = 8'hfa; 8'h15: o_byte = 8'h59; 8'h16: o_byte = 8'h47; 8'h17: o_byte = 8'hf0;
      8'h18: o_byte = 8'had; 8'h19: o_byte = 8'hd4; 8'h1a: o_byte = 8'ha2; 8'h1b: o_byte = 8'haf; 8'h1c: o_byte = 8'h9c; 8'h1d: o_byte = 8'ha4; 8'h1e: o_byte = 8'h72; 8'h1f: o_byte = 8'hc0;
      8'h20: o_byte = 8'hb7; 8'h21: o_byte = 8'hfd; 8'h22: o_byte = 8'h93; 8'h23: o_byte = 8'h26; 8'h24: o_byte = 8'h36; 8'h25: o_byte = 8'h3f; 8'h26: o_byte = 8'hf7; 8'h27: o_byte = 8'hcc;
      8'h28: o_byte = 8'h34; 8'h29: o_byte = 8'ha5; 8'h2a: o_byte = 8'he5; 8'h2b: o_byte = 8'hf1; 8'h2c: o_byte = 8'h71; 8'h2d: o_byte = 8'hd8; 8'h2e: o_byte = 8'h31; 8'h2f: o_byte = 8'h15;
      8'h30: o_byte = 8'h04; 8'h31: o_byte = 8'hc7; 8'h32: o_byte = 8'h23; 8'h33: o_byte = 8'hc3; 8'h34: o_byte = 8'h18; 8'h35: o_byte = 8'h96; 8'h36: o_byte = 8'h05; 8'h37: o_byte = 8'h9a;
      8'h38: o_byte = 8'h07; 8'h39: o_byte = 8'h12; 8'h3a: o_byte = 8'h80; 8'h3b: o_byte = 8'he2; 8'h3c: o_byte = 8'heb; 8'h3d: o_byte = 8'h27; 8'h3e: o_byte = 8'hb2; 8'h3f: o_byte = 8'h75;
      8'h40: o_byte = 8'h09; 8'h41: o_byte = 8'h83; 8'h42: o_byte = 8'h2c; 8'h43: o_byte = 8'h1a; 8'h44: o_byte = 8'h1b; 8'h45: o_byte = 8'h6e; 8'h46: o_byte = 8'h5a; 8'h47: o_byte = 8'ha0;
      8'h48: o_byte = 8'h52; 8'h49: o_byte = 8'h3b; 8'h4a: o_byte = 8'hd6; 8'h4b: o_byte = 8'hb3; 8'h4c: o_byte = 8'h29; 8'h4d: o_byte = 8'he3; 8'h4e: o_byte = 8'h2f; 8'h4f: o_byte = 8'h84;
      8'h50: o_byte = 8'h53; 8'h51: o_byte = 8'hd1; 8'h52: o_byte = 8'h00; 8'h53: o_byte = 8'hed; 8'h54: o_byte = 8'h20; 8'h55: o_byte = 8'hfc; 8'h56: o_byte = 8'hb1; 8'h57: o_byte = 8'h5b;
      8'h58: o_byte = 8'h6a; 8'h59: o_byte = 8'hcb; 8'h5a: o_byte = 8'hbe; 8'h5b: o_byte = 8'h39; 8'h5c: o_byte = 8'h4a; 8'h5d: o_byte = 8'h4c; 8'h5e: o_byte = 8'h58; 8'h5f: o_byte = 8'hcf;
      8'h60: o_byte = 8'hd0; 8'h61: o_byte = 8'hef; 8'h62: o_byte = 8'haa; 8'h63: o_byte = 8'hfb; 8'h64: o_byte = 8'h43; 8'h65: o_byte = 8'h4d; 8'h66: o_byte = 8'h33; 8'h67: o_byte = 8'h85;
      8'h68: o_byte = 8'h45; 8'h69: o_byte = 8'hf9; 8'h6a: o_byte = 8'h02; 8'h6b: o_byte = 8'h7f; 8'h6c: o_byte = 8'h50; 8'h6d: o_byte = 8'h3c; 8'h6e: o_byte = 8'h9f; 8'h6f: o_byte = 8'ha8;
      8'h70: o_byte = 8'h51; 8'h71: o_byte = 8'ha3; 8'h72: o_byte = 8'h40; 8'h73: o_byte = 8'h8f; 8'h74: o_byte = 8'h92; 8'h75: o_byte = 8'h9d; 8'h76: o_byte = 8'h38; 8'h77: o_byte = 8'hf5;
      8'h78: o_byte = 8'hbc; 8'h79: o_byte = 8'hb6; 8'h7a: o_byte = 8'hda; 8'h7b: o_byte = 8'h21; 8'h7c: o_byte = 8'h10; 8'h7d: o_byte = 8'hff; 8'h7e: o_byte = 8'hf3; 8'h7f: o_byte = 8'hd2;
      8'h80: o_byte = 8'hcd; 8'h81: o_byte = 8'h0c; 8'h82: o_byte = 8'h13; 8'h83: o_byte = 8'hec; 8'h84: o_byte = 8'h5f; 8'h85: o_byte = 8'h97; 8'h86: o_byte = 8'h44; 8'h87: o_byte = 8'h17;
      8'h88: o_byte = 8'hc4; 8'h89: o_byte = 8'ha7; 8'h8a: o_byte = 8'h7e; 8'h8b: o_byte = 8'h3d; 8'h8c: o_byte = 8'h64; 8'h8d: o_byte = 8'h5d; 8'h8e: o_byte = 8'h19; 8'h8f: o_byte = 8'h73;
      8'h90: o_byte = 8'h60; 8'h91: o_byte = 8'h81; 8'h92: o_byte = 8'h4f; 8'h93: o_byte = 8'hdc; 8'h94: o_byte = 8'h22; 8'h95: o_byte = 8'h2a; 8'h96: o_byte = 8'h90; 8'h97: o_byte = 8'h88;
      8'h98: o_byte = 8'h46; 8'h99: o_byte = 8'hee; 8'h9a: o_byte = 8'hb8; 8'h9b: o_byte = 8'h14; 8'h9c: o_byte = 8'hde; 8'h9d: o_byte = 8'h5e; 8'h9e: o_byte = 8'h0b; 8'h9f: o_byte = 8'hdb;
      8'ha0: o_byte = 8'he0; 8'ha1: o_byte = 8'h32; 8'ha2: o_byte = 8'h3a; 8'ha3: o_byte = 8'h0a; 8'ha4: o_byte = 8'h49; 8'ha5: o_byte = 8'h06; 8'ha6: o_byte = 8'h24; 8'ha7: o_byte = 8'h5c;
      8'ha8: o_byte = 8'hc2; 8'ha9: o_byte = 8'hd3; 8'haa: o_byte = 8'hac; 8'hab: o_byte = 8'h62; 8'hac: o_byte = 8'h91; 8'had: o_byte = 8'h95; 8'hae: o_byte = 8'he4; 8'haf: o_byte = 8'h79;
      8'hb0: o_byte = 8'he7; 8'hb1: o_byte = 8'hc8; 8'hb2: o_byte = 8'h37; 8'hb3: o_byte = 8'h6d; 8'hb4: o_byte = 8'h8d; 8'hb5: o_byte = 8'hd5; 8'hb6: o_byte = 8'h4e; 8'hb7: o_byte = 8'ha9;
      8'hb8: o_byte = 8'h6c; 8'hb9: o_byte = 8'h56; 8'hba: o_byte = 8'hf4; 8'hbb: o_byte = 8'hea; 8'hbc: o_byte = 8'h65; 8'hbd: o_byte = 8'h7a; 8'hbe: o_byte = 8'hae; 8'hbf: o_byte = 8'h08;
      8'hc0: o_byte = 8'hba; 8'hc1: o_byte = 8'h78; 8'hc2: o_byte = 8'h25; 8'hc3: o_byte = 8'h2e; 8'hc4: o_byte = 8'h1c; 8'hc5: o_byte = 8'ha6; 8'hc6: o_byte = 8'hb4; 8'hc7: o_byte = 8'hc6;
      8'hc8: o_byte = 8'he8; 8'hc9: o_byte = 8'hdd; 8'hca: o_byte = 8'h74; 8'hcb: o_byte = 8'h1f; 8'hcc: o_byte = 8'h4b; 8'hcd: o_byte = 8'hbd; 8'hce: o_byte = 8'h8b; 8'hcf: o_byte = 8'h8a;
      8'hd0: o_byte = 8'h70; 8'hd1: o_byte = 8'h3e; 8'hd2: o_byte = 8'hb5; 8'hd3: o_byte = 8'h66; 8'hd4: o_byte = 8'h48; 8'hd5: o_byte = 8'h03; 8'hd6: o_byte = 8'hf6; 8'hd7: o_byte = 8'h0e;
      8'hd8: o_byte = 8'h61; 8'hd9: o_byte = 8'h35; 8'hda: o_byte = 8'h57; 8'hdb: o_byte = 8'hb9; 8'hdc: o_byte = 8'h86; 8'hdd: o_byte = 8'hc1; 8'hde: o_byte = 8'h1d; 8'hdf: o_byte = 8'h9e;
      8'he0: o_byte = 8'he1; 8'he1: o_byte = 8'hf8; 8'he2: o_byte = 8'h98; 8'he3: o_byte = 8'h11; 8'he4: o_byte = 8'h69; 8'he5: o_byte = 8'hd9; 8'he6: o_byte = 8'h8e; 8'he7: o_byte = 8'h94;
      8'he8: o_byte = 8'h9b; 8'he9: o_byte = 8'h1e; 8'hea: o_byte = 8'h87; 8'heb: o_byte = 8'he9; 8'hec: o_byte = 8'hce; 8'hed: o_byte = 8'h55; 8'hee: o_byte = 8'h28; 8'hef: o_byte = 8'hdf;
      8'hf0: o_byte = 8'h8c; 8'hf1: o_byte = 8'ha1; 8'hf2: o_byte = 8'h89; 8'hf3: o_byte = 8'h0d; 8'hf4: o_byte = 8'hbf; 8'hf5: o_byte = 8'he6; 8'hf6: o_byte = 8'h42; 8'hf7: o_byte = 8'h68;
      8'hf8: o_byte = 8'h41; 8'hf9: o_byte = 8'h99; 8'hfa: o_byte = 8'h2d; 8'hfb: o_byte = 8'h0f; 8'hfc: o_byte = 8'hb0; 8'hfd: o_byte = 8'h54; 8'hfe: o_byte = 8'hbb; 8'hff: o_byte = 8'h16;
    endcase
  end

endmodule

// File: rtl/aes_top.sv
// Iterative AES-128 encryption core, one round per clock, on-the-fly key expansion.
// Optional macro AES_COMPLEMENT_OUT_EN adds registered complementary ciphertext/valid outputs.
module aes_top
  import aes_pkg::*;
(
  input  logic               AES_clk,
  input  logic               AES_rst,
  input  logic               AES_en,
  input  logic [STATE_W-1:0] AES_data_in,
  input  logic [STATE_W-1:0] AES_key_in,
  output logic [STATE_W-1:0] AES_data_out,
  output logic               AES_data_out_valid
`ifdef AES_COMPLEMENT_OUT_EN
  ,
  output logic [STATE_W-1:0] AES_data_out_complementary,
  output logic               AES_data_out_complementary_valid
`endif
);

  aes_fsm_e           r_fsm;
  logic [3:0]         r_round;
  logic               r_en_d;
  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] r_rkey;
  logic [STATE_W-1:0] r_data_out;
  logic               r_valid;

  logic               w_start;
  logic [7:0]         w_sb [16];
  logic [STATE_W-1:0] w_sr;
  logic [STATE_W-1:0] w_mc;
  logic [STATE_W-1:0] w_next_key;
  logic [31:0]        w_rot;
  logic [31:0]        w_subword;
  logic [31:0]        w_temp;
  logic [31:0]        w_k0, w_k1, w_k2, w_k3;

  assign w_start = AES_en & ~r_en_d & (r_fsm == IDLE);

  // Byte i of the state lives at [127-8i -: 8]; column c holds bytes 4c..4c+3.
  genvar gi, gc, gr;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_subbytes
      aes_sbox u_sbox (.i_byte(r_state[STATE_W-1-8*gi -: 8]), .o_byte(w_sb[gi]));
    end
    for (gc = 0; gc < 4; gc++) begin : g_col
      for (gr = 0; gr < 4; gr++) begin : g_row
        assign w_sr[STATE_W-1-8*(4*gc+gr) -: 8] = w_sb[4*((gc+gr)%4)+gr];
      end
      assign w_mc[STATE_W-1-32*gc -: 32] = mix_column(w_sr[STATE_W-1-32*gc -: 32]);
    end
    for (gi = 0; gi < 4; gi++) begin : g_subword
      aes_sbox u_sbox (.i_byte(w_rot[31-8*gi -: 8]), .o_byte(w_subword[31-8*gi -: 8]));
    end
  endgenerate

  // Next round key from the current one: RotWord/SubWord of w3 plus Rcon.
  assign w_rot      = {r_rkey[23:0], r_rkey[31:24]};
  assign w_temp     = w_subword ^ {RCON[r_round], 24'h000000};
  assign w_k0       = r_rkey[127:96] ^ w_temp;
  assign w_k1       = r_rkey[95:64]  ^ w_k0;
  assign w_k2       = r_rkey[63:32]  ^ w_k1;
  assign w_k3       = r_rkey[31:0]   ^ w_k2;
  assign w_next_key = {w_k0, w_k1, w_k2, w_k3};

  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      r_fsm      <= IDLE;
      r_round    <= 4'd0;
      r_en_d     <= 1'b0;
      r_state    <= '0;
      r_rkey     <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_en_d  <= AES_en;
      r_valid <= 1'b0;
      case (r_fsm)
        IDLE: begin
          if (w_start) begin
            r_state <= AES_data_in ^ AES_key_in;
            r_rkey  <= AES_key_in;
            r_round <= 4'd1;
            r_fsm   <= BUSY;
          end
        end
        BUSY: begin
          r_rkey <= w_next_key;
          // Final round drops MixColumns and publishes the result.
          if (r_round == 4'(NR)) begin
            r_data_out <= w_sr ^ w_next_key;
            r_valid    <= 1'b1;
            r_round    <= 4'd0;
            r_fsm      <= IDLE;
          end else begin
            r_state <= w_mc ^ w_next_key;
            r_round <= r_round + 4'd1;
          end
        end
      endcase
    end
  end

  assign AES_data_out       = r_data_out;
  assign AES_data_out_valid = r_valid;

`ifdef AES_COMPLEMENT_OUT_EN
  logic [STATE_W-1:0] r_data_out_n;
  logic               r_valid_n;

  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      r_data_out_n <= '0;
      r_valid_n    <= 1'b0;
    end else begin
      r_valid_n <= 1'b0;
      if (r_fsm == BUSY && r_round == 4'(NR)) begin
        r_data_out_n <= ~(w_sr ^ w_next_key);
        r_valid_n    <= 1'b1;
      end
    end
  end

  assign AES_data_out_complementary       = r_data_out_n;
  assign AES_data_out_complementary_valid = r_valid_n;
`endif

endmodule

// File: tb/tb_aes_top.sv
// Directed self-checking bench for aes_top using FIPS-197 / known-answer vectors.
// Define AES_COMPLEMENT_OUT_EN to also check the complementary outputs.
module tb_aes_top;

  logic         AES_clk;
  logic         AES_rst;
  logic         AES_en;
  logic [127:0] AES_data_in;
  logic [127:0] AES_key_in;
  logic [127:0] AES_data_out;
  logic         AES_data_out_valid;
`ifdef AES_COMPLEMENT_OUT_EN
  logic [127:0] AES_data_out_complementary;
  logic         AES_data_out_complementary_valid;
`endif

  int compareCount  = 0;
  int mismatchCount = 0;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT3  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_top dut (
    .AES_clk            (AES_clk),
    .AES_rst            (AES_rst),
    .AES_en             (AES_en),
    .AES_data_in        (AES_data_in),
    .AES_key_in         (AES_key_in),
    .AES_data_out       (AES_data_out),
    .AES_data_out_valid (AES_data_out_valid)
`ifdef AES_COMPLEMENT_OUT_EN
    ,
    .AES_data_out_complementary       (AES_data_out_complementary),
    .AES_data_out_complementary_valid (AES_data_out_complementary_valid)
`endif
  );

  initial AES_clk = 1'b0;
  always #5 AES_clk = ~AES_clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Ensures a fresh 0->1 edge on AES_en; the start edge is the next posedge.
  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] key);
    @(negedge AES_clk);
    AES_en = 1'b0;
    @(negedge AES_clk);
    AES_data_in = pt;
    AES_key_in  = key;
    AES_en      = 1'b1;
  endtask

  // Counts posedges (start edge = 1) until valid is seen; -1 if the bound expires.
  task automatic waitValid(input bit scramble, output int cycles);
    cycles = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge AES_clk);
      #1;
      if (scramble) begin
        AES_data_in = {$urandom, $urandom, $urandom, $urandom};
        AES_key_in  = {$urandom, $urandom, $urandom, $urandom};
      end
      if (AES_data_out_valid) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic countPulses(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge AES_clk);
      #1;
      if (AES_data_out_valid) pulses++;
    end
  endtask

  initial begin
    int lat;
    int pulses;

    AES_rst     = 1'b1;
    AES_en      = 1'b0;
    AES_data_in = '0;
    AES_key_in  = '0;
    repeat (3) @(posedge AES_clk);
    #1;
    checkOutput("reset_data", AES_data_out, 128'h0);
    checkOutput("reset_valid", {127'h0, AES_data_out_valid}, 128'h0);
    @(negedge AES_clk);
    AES_rst = 1'b0;

    // Vector 1: result, latency and single-cycle valid.
    applyStimulus(PT1, KEY1);
    waitValid(1'b0, lat);
    checkOutput("v1_latency", 128'(lat), 128'd11);
    checkOutput("v1_data", AES_data_out, CT1);
`ifdef AES_COMPLEMENT_OUT_EN
    checkOutput("v1_comp_data", AES_data_out_complementary, ~CT1);
    checkOutput("v1_comp_valid", {127'h0, AES_data_out_complementary_valid}, 128'h1);
`endif
    @(posedge AES_clk);
    #1;
    checkOutput("v1_valid_one_cycle", {127'h0, AES_data_out_valid}, 128'h0);
`ifdef AES_COMPLEMENT_OUT_EN
    checkOutput("v1_comp_valid_drop", {127'h0, AES_data_out_complementary_valid}, 128'h0);
`endif

    // Vector 2.
    applyStimulus(PT2, KEY2);
    waitValid(1'b0, lat);
    checkOutput("v2_latency", 128'(lat), 128'd11);
    checkOutput("v2_data", AES_data_out, CT2);

    // Vector 3 with AES_en held high for 50 cycles: one pulse only.
    applyStimulus(128'h0, 128'h0);
    countPulses(50, pulses);
    checkOutput("v3_pulses", 128'(pulses), 128'd1);
    checkOutput("v3_data", AES_data_out, CT3);

    // Inputs scrambled while busy must not affect the result; output then holds.
    applyStimulus(PT1, KEY1);
    waitValid(1'b1, lat);
    checkOutput("v4_latency", 128'(lat), 128'd11);
    checkOutput("v4_data", AES_data_out, CT1);
    @(negedge AES_clk);
    AES_en      = 1'b0;
    AES_data_in = PT2;
    AES_key_in  = KEY2;
    repeat (4) @(posedge AES_clk);
    #1;
    checkOutput("v4_hold", AES_data_out, CT1);

    // A rising AES_en while busy is dropped, not queued.
    applyStimulus(PT2, KEY2);
    repeat (4) @(negedge AES_clk);
    AES_en = 1'b0;
    @(negedge AES_clk);
    AES_en = 1'b1;
    countPulses(30, pulses);
    checkOutput("busy_edge_pulses", 128'(pulses), 128'd1);
    checkOutput("busy_edge_data", AES_data_out, CT2);

    // Reset during round 5 aborts immediately with no valid.
    applyStimulus(PT1, KEY1);
    repeat (5) @(posedge AES_clk);
    @(negedge AES_clk);
    AES_rst = 1'b1;
    AES_en  = 1'b0;
    #1;
    checkOutput("abort_data", AES_data_out, 128'h0);
    checkOutput("abort_valid", {127'h0, AES_data_out_valid}, 128'h0);
    @(negedge AES_clk);
    AES_rst = 1'b0;
    countPulses(15, pulses);
    checkOutput("abort_no_pulse", 128'(pulses), 128'd0);

    applyStimulus(PT2, KEY2);
    waitValid(1'b0, lat);
    checkOutput("restart_latency", 128'(lat), 128'd11);
    checkOutput("restart_data", AES_data_out, CT2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
